// File: rtl/alu_serial_mem_port_pkg.sv
// Shared types and defaults for the memory-side serial port of the bit-serial ALU.
package alu_serial_mem_port_pkg;

  localparam int unsigned REG_BITS_DEF = 8;
  localparam int unsigned NSHIFT_DEF   = 2;

  typedef enum logic [1:0] {
    PORT_IDLE   = 2'd0,
    PORT_FETCH  = 2'd1,
    PORT_STREAM = 2'd2,
    PORT_WRITE  = 2'd3
  } port_state_e;

  // Transfer options captured when a transfer starts.
  typedef struct packed {
    logic pair;
    logic need_read;
    logic need_write;
  } xfer_cfg_t;

endpackage

// File: rtl/alu_serial_mem_port_serdes_shift.sv
// Word-wide shift register: parallel load, NSHIFT-bit chunks shifted in at the MSB end.
module alu_serial_mem_port_serdes_shift #(
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned NSHIFT    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WORD_BITS-1:0] load_data,
  input  logic                 shift_en,
  input  logic [NSHIFT-1:0]    ser_in,
  output logic [WORD_BITS-1:0] q
);

  // Load wins over shift; the low chunk is what the next shift drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {ser_in, q[WORD_BITS-1:NSHIFT]};
    end
  end

endmodule

// File: rtl/alu_serial_mem_port.sv
// Memory-side endpoint of the ALU serial path: serializes bus reads into the ALU and
// collects the ALU serial result into a parallel bus write.
module alu_serial_mem_port
  import alu_serial_mem_port_pkg::*;
#(
  parameter int unsigned REG_BITS  = REG_BITS_DEF,
  parameter int unsigned NSHIFT    = NSHIFT_DEF,
  parameter int unsigned WORD_BITS = 2 * REG_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 pair,
  input  logic                 need_read,
  input  logic                 need_write,
  input  logic                 rd_valid,
  input  logic [WORD_BITS-1:0] rd_data,
  output logic                 rd_ready,
  input  logic                 active,
  output logic [NSHIFT-1:0]    data_in,
  input  logic [NSHIFT-1:0]    data_out,
  output logic                 ready,
  output logic                 wr_valid,
  output logic [WORD_BITS-1:0] wr_data,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned WORD_CHUNKS = WORD_BITS / NSHIFT;
  localparam int unsigned BYTE_CHUNKS = REG_BITS / NSHIFT;
  localparam int unsigned CNT_W       = $clog2(WORD_CHUNKS);
  localparam int unsigned PAD_BITS    = WORD_BITS - REG_BITS;

  port_state_e            state_q, state_d;
  xfer_cfg_t              cfg_q, cfg_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       last_chunk;
  logic                   done_d;
  logic                   in_load;
  logic [WORD_BITS-1:0]   in_load_data;
  logic                   out_load;
  logic                   shift_en;
  logic [WORD_BITS-1:0]   in_q;
  logic [WORD_BITS-1:0]   out_q;
  logic                   unused_in_hi;

  assign last_chunk = cfg_q.pair ? CNT_W'(WORD_CHUNKS - 1) : CNT_W'(BYTE_CHUNKS - 1);

  alu_serial_mem_port_serdes_shift #(
    .WORD_BITS (WORD_BITS),
    .NSHIFT    (NSHIFT)
  ) u_in_sreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (in_load),
    .load_data (in_load_data),
    .shift_en  (shift_en),
    .ser_in    ({NSHIFT{1'b0}}),
    .q         (in_q)
  );

  alu_serial_mem_port_serdes_shift #(
    .WORD_BITS (WORD_BITS),
    .NSHIFT    (NSHIFT)
  ) u_out_sreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (out_load),
    .load_data ({WORD_BITS{1'b0}}),
    .shift_en  (shift_en),
    .ser_in    (data_out),
    .q         (out_q)
  );

  // Only the low chunk of the operand register ever leaves the block.
  assign unused_in_hi = ^in_q[WORD_BITS-1:NSHIFT];

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    count_d      = count_q;
    done_d       = 1'b0;
    in_load      = 1'b0;
    in_load_data = '0;
    out_load     = 1'b0;
    shift_en     = 1'b0;

    case (state_q)
      PORT_IDLE: begin
        if (start) begin
          cfg_d.pair       = pair;
          cfg_d.need_read  = need_read;
          cfg_d.need_write = need_write;
          count_d          = '0;
          out_load         = 1'b1;
          if (need_read) begin
            state_d = PORT_FETCH;
          end else begin
            in_load = 1'b1;
            state_d = PORT_STREAM;
          end
        end
      end
      PORT_FETCH: begin
        if (rd_valid && rd_ready) begin
          in_load      = 1'b1;
          in_load_data = cfg_q.pair ? rd_data : {{PAD_BITS{1'b0}}, rd_data[REG_BITS-1:0]};
          state_d      = PORT_STREAM;
        end
      end
      PORT_STREAM: begin
        if (active) begin
          shift_en = 1'b1;
          count_d  = count_q + CNT_W'(1);
          if (count_q == last_chunk) begin
            if (cfg_q.need_write) begin
              state_d = PORT_WRITE;
            end else begin
              state_d = PORT_IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      PORT_WRITE: begin
        if (wr_ready) begin
          state_d = PORT_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = PORT_IDLE;
    endcase
  end

  // State register; handshake flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PORT_IDLE;
      cfg_q    <= '0;
      count_q  <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      rd_ready <= 1'b0;
      wr_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      count_q  <= count_d;
      done     <= done_d;
      busy     <= (state_d != PORT_IDLE);
      ready    <= (state_d == PORT_STREAM);
      rd_ready <= (state_d == PORT_FETCH);
      wr_valid <= (state_d == PORT_WRITE);
      err      <= err | (active & ~ready);
    end
  end

  assign data_in = ready ? in_q[NSHIFT-1:0] : '0;

  // Byte results sit in the top byte after four shifts; present them zero-extended.
  assign wr_data = !wr_valid  ? '0 :
                   cfg_q.pair ? out_q :
                                {{PAD_BITS{1'b0}}, out_q[WORD_BITS-1:REG_BITS]};

endmodule
